// File: rtl/staging_arbiter_if.sv
// Request/response bundle for staging_arbiter: four 32-bit requesters in, one staged result out.
// The arbiter takes the slave view; the requesters and the result consumer take the master view.
interface staging_arbiter_if;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/staging_arbiter.sv
// Four-way arbiter that stages one operand at a time through IDLE -> COMPUTE -> RESP.
// Define STAGING_ARB_RR_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
module staging_arbiter #(
    parameter logic [31:0] THRESHOLD = 32'd100,
    parameter logic [15:0] TAG       = 16'h0ABC
) (
    input  logic                clk,
    input  logic                reset,
    staging_arbiter_if.slave    bus,
    output logic                busy,
    output logic [15:0]         done_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] cap_data;
    logic [1:0]  cap_id;
    logic [31:0] out_data_q;
    logic [1:0]  out_id_q;
    logic        out_valid_q;

    logic [1:0]  search_base;
    logic [1:0]  idx;
    logic [1:0]  win_id;
    logic [3:0]  grant;
    logic        take;
    logic [15:0] sum;
    logic        qualify;

`ifdef STAGING_ARB_RR_EN
    logic [1:0] ptr;
    assign search_base = ptr;
`else
    assign search_base = 2'd0;
`endif

    // Walk from the highest offset down so the requester closest to search_base wins last.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant  = '0;
        win_id = search_base;
        idx    = search_base;
        for (int k = 3; k >= 0; k--) begin
            idx = search_base + 2'(k);
            if (bus.req_valid[idx]) begin
                grant  = 4'b0001 << idx;
                win_id = idx;
            end
        end
    end

    // Gating with reset keeps req_ready low while reset is held, even though state already reads IDLE.
    assign take          = (state == IDLE) && (|bus.req_valid) && reset;
    assign bus.req_ready = take ? grant : 4'b0000;

    assign sum     = cap_data[31:16] + cap_data[15:0];
    assign qualify = (cap_data > THRESHOLD) && (cap_data[31:16] == 16'd1);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cap_data    <= '0;
            cap_id      <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            done_count  <= '0;
`ifdef STAGING_ARB_RR_EN
            ptr         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        cap_data <= bus.req_data[{win_id, 5'd0} +: 32];
                        cap_id   <= win_id;
                        state    <= COMPUTE;
`ifdef STAGING_ARB_RR_EN
                        ptr      <= win_id + 2'd1;
`endif
                    end
                end
                COMPUTE: begin
                    out_data_q  <= qualify ? {TAG, sum} : {TAG, 16'd1};
                    out_id_q    <= cap_id;
                    out_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        done_count  <= done_count + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign busy          = (state != IDLE);

endmodule

// File: doc/staging_arbiter.md
STAGING_ARBITER -- requirements
Module: staging_arbiter

Interface
REQ-001 SHALL provide parameter THRESHOLD, default 32'd100, meaning the lower bound for the compute path (strictly greater than).
REQ-002 SHALL provide parameter TAG, default 16'd2748 (0x0ABC), meaning the constant placed in out_data[31:16].
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port req_valid  input  4  per-requester request valid, index i = requester i.
REQ-006 SHALL provide port req_data  input  128  per-requester operand; requester i occupies bits [32i+31:32i].
REQ-007 SHALL provide port req_ready  output  4  per-requester accept strobe; at most one bit high.
REQ-008 SHALL provide port out_valid  output  1  result valid.
REQ-009 SHALL provide port out_ready  input  1  downstream accept.
REQ-010 SHALL provide port out_data  output  32  staged result.
REQ-011 SHALL provide port out_id  output  2  index of the requester that owns out_data.
REQ-012 SHALL provide port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL provide port done_count  output  16  count of completed output handshakes; wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL implement FSM states IDLE, COMPUTE, RESP; transitions: IDLE->COMPUTE on a request handshake, COMPUTE->RESP unconditionally, RESP->IDLE on out_valid&&out_ready.
REQ-015 SHALL, in IDLE with any req_valid high, drive req_ready combinationally one-hot to the arbitration winner; req_ready SHALL be 0 in COMPUTE and RESP.
REQ-016 SHALL capture the winner's req_data and index on the handshake edge; requesters hold req_valid and req_data until their req_ready is seen.
REQ-017 SHALL, in COMPUTE, register out_data = {TAG, d[31:16]+d[15:0]} (16-bit sum, carry discarded) when d > THRESHOLD and d[31:16]==16'd1; otherwise out_data = {TAG, 16'd1}.
REQ-018 SHALL assert out_valid exactly when in RESP; the result is visible in the cycle after the COMPUTE edge (2 edges after handshake edge).
REQ-019 SHALL hold out_valid, out_data and out_id stable while out_valid && !out_ready.
REQ-020 SHALL increment done_count by 1 on each out_valid&&out_ready edge.
REQ-021 SHALL NOT accept a new request in the RESP->IDLE edge; minimum spacing between handshakes is 3 cycles.
REQ-022 SHALL ignore req_valid changes while not in IDLE.

Reset
REQ-023 SHALL, when reset is low, immediately force state IDLE, out_valid 0, out_data 0, out_id 0, busy 0, done_count 0, arbitration pointer 0, req_ready 0.
REQ-024 SHALL discard any captured or in-flight request on reset; no response is produced for it after release.
REQ-025 SHALL resume arbitration on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL use macro STAGING_ARB_RR_EN: when defined, arbitration is round-robin, searching from pointer upward modulo 4; pointer becomes winner+1 (mod 4) on each handshake.
REQ-027 SHALL, when STAGING_ARB_RR_EN is undefined, use fixed priority (lowest index wins), with the pointer logic removed.

Verification
REQ-028 SHALL cover: req_valid=4'b0001, req0=0x0001_0080 -> req_ready=4'b0001 that cycle; out_valid 2 edges later with out_data=0x0ABC_0081, out_id=0; done_count=1 after out_ready.
REQ-029 SHALL cover: req2=0x0000_0064 (equals THRESHOLD) -> out_data=0x0ABC_0001, out_id=2; req2=0x0002_0100 -> 0x0ABC_0001.
REQ-030 SHALL cover: req1=0x0001_FFFF -> out_data=0x0ABC_0000 (sum wraps), out_id=1.
REQ-031 SHALL cover: all four req_valid held high, out_ready=1 -> with STAGING_ARB_RR_EN out_id sequence 0,1,2,3,0; without it out_id 0,0,0,0.
REQ-032 SHALL cover: out_ready held low 5 cycles in RESP -> out_valid, out_data, out_id unchanged, req_ready=0, done_count unchanged until the out_ready edge.
REQ-033 SHALL cover: reset pulsed low during COMPUTE -> outputs 0 asynchronously; after release with req_valid=0, out_valid stays 0 and done_count stays 0.
